// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//   Owns the program counter of the single-issue CPU. Each cycle it decides
//   whether the PC advances (PC+4), branches (PC+4+offset*4) or holds because
//   of a memory stall or a multi-cycle MULT. It also qualifies the register
//   file write enable so that each instruction writes exactly once, in the
//   cycle in which the PC advances.
//
// Ports
//   CLK             in   clock, all state updates on the rising edge
//   RESET           in   synchronous active-low reset
//   ALUOP[2:0]      in   ALU operation, 3'b100 = MULT
//   WRITEENABLE_IN  in   register write request from the control unit
//   BRANCH[1:0]     in   00 sequential, 01 jump, 10 BEQ, 11 BNE
//   ZERO            in   ALU zero flag of the current instruction
//   OFFSET[7:0]     in   signed branch/jump offset in instruction words
//   BUSYWAIT        in   memory stall request
//   PC              out  current program counter (register)
//   STALL           out  PC will not change at the next edge
//   WRITEENABLE_OUT out  qualified register-file write enable
//   BRANCH_TAKEN    out  branch decision for the current instruction
// ----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int                  PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
   parameter int                  MULT_LATENCY = 3
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [2:0]          ALUOP,
   input  logic                WRITEENABLE_IN,
   input  logic [1:0]          BRANCH,
   input  logic                ZERO,
   input  logic [7:0]          OFFSET,
   input  logic                BUSYWAIT,
   output logic [PC_WIDTH-1:0] PC,
   output logic                STALL,
   output logic                WRITEENABLE_OUT,
   output logic                BRANCH_TAKEN
);

   // CNT only ever holds values up to MULT_LATENCY-1
   localparam int               CNT_W      = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'((MULT_LATENCY > 1) ? (MULT_LATENCY - 1) : 0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic             MULT_MC    = (MULT_LATENCY > 1) ? 1'b1 : 1'b0;
   localparam logic [2:0]       ALUOP_MULT = 3'b100;

   typedef enum logic [0:0] {
      ST_RUN       = 1'b0,
      ST_MULT_WAIT = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [PC_WIDTH-1:0]   r_pc;
   logic [PC_WIDTH-1:0]   w_pc_nxt;
   logic [PC_WIDTH-1:0]   w_pc_adv;
   logic [PC_WIDTH-1:0]   w_offset_ext;
   logic                  w_taken;
   logic                  w_stall;
   logic                  w_is_mult;
   logic                  w_cnt_gt1;

   // A MULT only needs the wait state when it spans more than one cycle
   assign w_is_mult = MULT_MC & (ALUOP == ALUOP_MULT);
   assign w_cnt_gt1 = (r_cnt > CNT_ONE);

   // Word offset -> byte offset, sign-extended to the PC width
   assign w_offset_ext = {{(PC_WIDTH-10){OFFSET[7]}}, OFFSET, 2'b00};

   // Branch decision from the branch type and the ALU zero flag
   always_comb begin
      w_taken = 1'b0;
      case (BRANCH)
         2'b00:   w_taken = 1'b0;
         2'b01:   w_taken = 1'b1;
         2'b10:   w_taken = ZERO;
         2'b11:   w_taken = ~ZERO;
         default: w_taken = 1'b0;
      endcase
   end

   // Address of the following instruction; wraps silently at 2^PC_WIDTH
   assign w_pc_adv = r_pc + PC_WIDTH'(32'd4) + (w_taken ? w_offset_ext : {PC_WIDTH{1'b0}});

   // Stall whenever the PC will not move at the coming edge
   always_comb begin
      w_stall = 1'b0;
      if (!RESET) begin
         w_stall = 1'b1;
      end else if (BUSYWAIT) begin
         w_stall = 1'b1;
      end else begin
         case (r_state)
            ST_RUN:       w_stall = w_is_mult;
            ST_MULT_WAIT: w_stall = w_cnt_gt1;
            default:      w_stall = 1'b0;
         endcase
      end
   end

   // Next-state, next-count and next-PC selection
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pc_nxt    = r_pc;
      if (BUSYWAIT) begin
         // memory stall freezes everything, in either state
         w_state_nxt = r_state;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_is_mult) begin
                  w_cnt_nxt   = CNT_LOAD;
                  w_state_nxt = ST_MULT_WAIT;
               end else begin
                  w_pc_nxt = w_pc_adv;
               end
            end
            ST_MULT_WAIT: begin
               if (w_cnt_gt1) begin
                  w_cnt_nxt = r_cnt - CNT_ONE;
               end else begin
                  w_pc_nxt    = w_pc_adv;
                  w_cnt_nxt   = CNT_ZERO;
                  w_state_nxt = ST_RUN;
               end
            end
            default: begin
               w_cnt_nxt   = CNT_ZERO;
               w_state_nxt = ST_RUN;
            end
         endcase
      end
   end

   // State, counter and PC registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_pc    <= RESET_PC;
         r_state <= ST_RUN;
         r_cnt   <= CNT_ZERO;
      end else begin
         r_pc    <= w_pc_nxt;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign PC              = r_pc;
   assign STALL           = w_stall;
   assign WRITEENABLE_OUT = WRITEENABLE_IN & ~w_stall;
   assign BRANCH_TAKEN    = w_taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
//   Two instances share the stimulus: dut3 with MULT_LATENCY=3 and dut1 with
//   MULT_LATENCY=1. The driver applies one cycle of inputs, asks a reference
//   model (instruction progress counted in productive cycles) for the outputs
//   expected in that cycle and queues them; a monitor on the falling edge pops
//   and compares. New instructions are only issued when the latency-3 model
//   reports the current one complete, so inputs stay stable while it stalls.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

   typedef struct {
      logic [31:0] pc;
      logic        stall;
      logic        we;
      logic        bt;
   } exp_t;

   logic        CLK = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  aluop = 3'd0;
   logic        we_in = 1'b0;
   logic [1:0]  br = 2'd0;
   logic        zero = 1'b0;
   logic [7:0]  off = 8'd0;
   logic        busy = 1'b0;

   logic [31:0] pc3, pc1;
   logic        stall3, stall1, weo3, weo1, bt3, bt1;

   int n_checks = 0;
   int n_errors = 0;

   exp_t q3[$];
   exp_t q1[$];

   // model state per instance: 0 -> latency 3, 1 -> latency 1
   logic [31:0] m_pc   [2] = '{32'h0, 32'h0};
   int          m_prog [2] = '{0, 0};
   int          m_need [2] = '{1, 1};
   int          ml     [2] = '{3, 1};

   always #5 CLK = ~CLK;

   pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .MULT_LATENCY(3)) dut3 (
      .CLK(CLK), .RESET(rst), .ALUOP(aluop), .WRITEENABLE_IN(we_in), .BRANCH(br),
      .ZERO(zero), .OFFSET(off), .BUSYWAIT(busy), .PC(pc3), .STALL(stall3),
      .WRITEENABLE_OUT(weo3), .BRANCH_TAKEN(bt3));

   pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .MULT_LATENCY(1)) dut1 (
      .CLK(CLK), .RESET(rst), .ALUOP(aluop), .WRITEENABLE_IN(we_in), .BRANCH(br),
      .ZERO(zero), .OFFSET(off), .BUSYWAIT(busy), .PC(pc1), .STALL(stall1),
      .WRITEENABLE_OUT(weo1), .BRANCH_TAKEN(bt1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an instruction needs `need` non-busy cycles
   // (MULT_LATENCY for MULT, else 1); the PC moves on the last of them.
   task automatic model(input int k, output exp_t e, output bit done);
      bit taken;
      int need;
      int o;
      taken  = (br == 2'd1) || (br == 2'd2 && zero) || (br == 2'd3 && !zero);
      e.pc   = m_pc[k];
      e.bt   = taken;
      done   = 1'b0;
      if (!rst) begin
         e.stall   = 1'b1;
         e.we      = 1'b0;
         m_pc[k]   = 32'h0;
         m_prog[k] = 0;
         m_need[k] = 1;
         done      = 1'b1;
      end else begin
         need    = (m_prog[k] > 0) ? m_need[k] : ((aluop == 3'b100) ? ml[k] : 1);
         e.stall = busy || (m_prog[k] + 1 < need);
         e.we    = we_in && !e.stall;
         if (!busy) begin
            if (m_prog[k] + 1 < need) begin
               m_prog[k] = m_prog[k] + 1;
               m_need[k] = need;
            end else begin
               o         = $signed(off);
               m_pc[k]   = m_pc[k] + 32'(4 + (taken ? 4 * o : 0));
               m_prog[k] = 0;
               done      = 1'b1;
            end
         end
      end
   endtask

   // Drive one cycle, queue expectations, advance to just after the edge
   task automatic step(input logic r, input logic [2:0] a, input logic w, input logic [1:0] b,
                       input logic z, input logic [7:0] o, input logic bw, output bit done);
      exp_t e3, e1;
      bit   d1;
      rst = r; aluop = a; we_in = w; br = b; zero = z; off = o; busy = bw;
      model(0, e3, done);
      model(1, e1, d1);
      q3.push_back(e3);
      q1.push_back(e1);
      @(posedge CLK);
      #1;
   endtask

   // Run one instruction without memory stalls until the latency-3 model completes it
   task automatic run_instr(input logic [2:0] a, input logic w, input logic [1:0] b,
                            input logic z, input logic [7:0] o);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) step(1'b1, a, w, b, z, o, 1'b0, done);
      if (!done) chk("instr_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: compare every presented cycle against the queued expectation
   always @(negedge CLK) begin
      exp_t e;
      if (q3.size() > 0) begin
         e = q3.pop_front();
         chk("pc_l3",    pc3,           e.pc);
         chk("stall_l3", {31'd0, stall3}, {31'd0, e.stall});
         chk("we_l3",    {31'd0, weo3},   {31'd0, e.we});
         chk("bt_l3",    {31'd0, bt3},    {31'd0, e.bt});
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         chk("pc_l1",    pc1,           e.pc);
         chk("stall_l1", {31'd0, stall1}, {31'd0, e.stall});
         chk("we_l1",    {31'd0, weo1},   {31'd0, e.we});
      end
   end

   localparam logic [2:0] ADD  = 3'b001;
   localparam logic [2:0] MULT = 3'b100;

   initial begin
      bit done;
      logic [2:0] ra;
      logic [1:0] rb;
      logic       rw, rz;
      logic [7:0] ro;
      int         cyc;

      @(posedge CLK);
      #1;
      step(1'b0, ADD, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, done);
      chk("first_reset_pc", pc3, 32'h0);

      // sequential fetch to 0x40, reset, then sequential again
      for (int i = 0; i < 16; i++) run_instr(ADD, 1'b1, 2'd0, 1'b0, 8'd0);
      chk("fetch_0x40", pc3, 32'h40);
      step(1'b0, ADD, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0, done);
      step(1'b0, ADD, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0, done);
      chk("reset_pc", pc3, 32'h0);
      run_instr(ADD, 1'b1, 2'd0, 1'b0, 8'd0);
      chk("seq_4", pc3, 32'h4);
      run_instr(ADD, 1'b1, 2'd0, 1'b0, 8'd0);
      chk("seq_8", pc3, 32'h8);

      // MULT stretch
      run_instr(MULT, 1'b1, 2'd0, 1'b0, 8'd0);
      chk("mult_pc", pc3, 32'hC);

      // branches
      for (int i = 0; i < 5; i++) run_instr(ADD, 1'b1, 2'd0, 1'b0, 8'd0);
      chk("pc_0x20", pc3, 32'h20);
      run_instr(ADD, 1'b0, 2'd2, 1'b1, 8'hFE);
      chk("beq_taken", pc3, 32'h1C);
      run_instr(ADD, 1'b1, 2'd0, 1'b0, 8'd0);
      run_instr(ADD, 1'b0, 2'd2, 1'b0, 8'hFE);
      chk("beq_not_taken", pc3, 32'h24);
      run_instr(ADD, 1'b0, 2'd1, 1'b0, 8'hFE);
      chk("jump_back", pc3, 32'h20);
      run_instr(ADD, 1'b0, 2'd3, 1'b0, 8'h02);
      chk("bne_taken", pc3, 32'h2C);
      run_instr(ADD, 1'b0, 2'd1, 1'b1, 8'hF8);
      chk("jump_0x10", pc3, 32'h10);
      run_instr(ADD, 1'b0, 2'd1, 1'($urandom_range(1, 0)), 8'h03);
      chk("jump_fwd", pc3, 32'h20);
      run_instr(ADD, 1'b0, 2'd1, 1'b0, 8'h03);
      chk("pc_0x30", pc3, 32'h30);

      // memory stall
      for (int i = 0; i < 4; i++) step(1'b1, ADD, 1'b1, 2'd0, 1'b0, 8'd0, 1'b1, done);
      chk("busy_hold", pc3, 32'h30);
      run_instr(ADD, 1'b1, 2'd0, 1'b0, 8'd0);
      chk("busy_release", pc3, 32'h34);

      // BUSYWAIT during MULT_WAIT with CNT=2
      step(1'b1, MULT, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0, done);
      step(1'b1, MULT, 1'b1, 2'd0, 1'b0, 8'd0, 1'b1, done);
      step(1'b1, MULT, 1'b1, 2'd0, 1'b0, 8'd0, 1'b1, done);
      step(1'b1, MULT, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0, done);
      chk("mult_busy_hold", pc3, 32'h34);
      step(1'b1, MULT, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0, done);
      chk("mult_busy_done", pc3, 32'h38);

      // wrap-around
      step(1'b0, ADD, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, done);
      run_instr(ADD, 1'b0, 2'd1, 1'b0, 8'hFE);
      chk("pc_top", pc3, 32'hFFFF_FFFC);
      run_instr(ADD, 1'b1, 2'd0, 1'b0, 8'd0);
      chk("pc_wrap", pc3, 32'h0);

      // reset while in MULT_WAIT with BUSYWAIT high
      step(1'b1, MULT, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0, done);
      step(1'b1, MULT, 1'b1, 2'd0, 1'b0, 8'd0, 1'b1, done);
      step(1'b0, MULT, 1'b1, 2'd0, 1'b0, 8'd0, 1'b1, done);
      chk("reset_mid_mult", pc3, 32'h0);
      run_instr(ADD, 1'b1, 2'd0, 1'b0, 8'd0);
      chk("after_reset_mult", pc3, 32'h4);

      // randomized instruction stream
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(49, 0) == 0) begin
            step(1'b0, ADD, 1'b1, 2'd0, 1'b0, 8'd0, 1'($urandom_range(1, 0)), done);
         end else begin
            ra = ($urandom_range(3, 0) == 0) ? MULT : 3'($urandom_range(7, 0));
            rw = 1'($urandom_range(1, 0));
            rb = (ra == MULT) ? 2'd0 : 2'($urandom_range(3, 0));
            rz = 1'($urandom_range(1, 0));
            ro = 8'($urandom_range(255, 0));
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < 40) begin
               step(1'b1, ra, rw, rb, rz, ro, ($urandom_range(3, 0) == 0) ? 1'b1 : 1'b0, done);
               cyc++;
            end
            if (!done) chk("random_timeout", 32'd0, 32'd1);
         end
      end

      repeat (3) @(negedge CLK);
      chk("queue_drained", 32'(q3.size() + q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
